// File: rtl/riscv_wb_arbiter_if.sv
// Write-back bus bundle between the result producers, the register file and the arbiter.
// The slave modport is the arbiter. The master modport is the surrounding core or bench.
interface riscv_wb_arbiter_if #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32
);
  logic                       alu_valid_i;
  logic [ADDR_WIDTH-1:0]      alu_waddr_i;
  logic [DATA_WIDTH-1:0]      alu_wdata_i;
  logic                       lsu_valid_i;
  logic                       lsu_ready_o;
  logic [ADDR_WIDTH-1:0]      lsu_waddr_i;
  logic [DATA_WIDTH-1:0]      lsu_wdata_i;
  logic                       lng_valid_i;
  logic                       lng_ready_o;
  logic [ADDR_WIDTH-1:0]      lng_waddr_i;
  logic [DATA_WIDTH-1:0]      lng_wdata_i;
  logic [ADDR_WIDTH-1:0]      waddr_a_o;
  logic [DATA_WIDTH-1:0]      wdata_a_o;
  logic                       we_a_o;
  logic [ADDR_WIDTH-1:0]      waddr_b_o;
  logic [DATA_WIDTH-1:0]      wdata_b_o;
  logic                       we_b_o;
  logic [2**ADDR_WIDTH-1:0]   pending_o;
  logic [3:0]                 fifo_cnt_o;

  modport slave (
    input  alu_valid_i, alu_waddr_i, alu_wdata_i,
    input  lsu_valid_i, lsu_waddr_i, lsu_wdata_i,
    input  lng_valid_i, lng_waddr_i, lng_wdata_i,
    output lsu_ready_o, lng_ready_o,
    output waddr_a_o, wdata_a_o, we_a_o,
    output waddr_b_o, wdata_b_o, we_b_o,
    output pending_o, fifo_cnt_o
  );

  modport master (
    output alu_valid_i, alu_waddr_i, alu_wdata_i,
    output lsu_valid_i, lsu_waddr_i, lsu_wdata_i,
    output lng_valid_i, lng_waddr_i, lng_wdata_i,
    input  lsu_ready_o, lng_ready_o,
    input  waddr_a_o, wdata_a_o, we_a_o,
    input  waddr_b_o, wdata_b_o, we_b_o,
    input  pending_o, fifo_cnt_o
  );
endinterface

// File: rtl/riscv_wb_arbiter.sv
// Register-file write-back arbiter. Port A carries ALU results. Port B carries LSU results and
// drains a long-latency result FIFO, with a starvation guard.
module riscv_wb_arbiter #(
  parameter int ADDR_WIDTH   = 6,
  parameter int DATA_WIDTH   = 32,
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  riscv_wb_arbiter_if.slave    bus
);

  localparam int PW = (DEPTH <= 2) ? 1 : $clog2(DEPTH);
  localparam int NREG = 2**ADDR_WIDTH;

  logic [ADDR_WIDTH-1:0] fifo_addr [0:DEPTH-1];
  logic [DATA_WIDTH-1:0] fifo_data [0:DEPTH-1];
  logic [DEPTH-1:0]      fifo_vld;
  logic [PW-1:0]         head, tail;
  logic [3:0]            cnt;
  logic [3:0]            starve;

  logic                  fifo_empty;
  logic                  force_pop;
  logic                  pop, push, lsu_sel;
  logic [PW-1:0]         head_nxt, tail_nxt;
  logic [ADDR_WIDTH-1:0] head_addr;
  logic [DATA_WIDTH-1:0] head_data;
  logic [NREG-1:0]       pend;

  always_comb begin
    fifo_empty = (cnt == 4'd0);
    force_pop  = !fifo_empty && (starve == 4'(STARVE_LIMIT));
    lsu_sel    = bus.lsu_valid_i && !force_pop;
    pop        = !fifo_empty && (force_pop || !bus.lsu_valid_i);
    push       = bus.lng_valid_i && bus.lng_ready_o;
    head_nxt   = (head == PW'(DEPTH-1)) ? '0 : head + 1'b1;
    tail_nxt   = (tail == PW'(DEPTH-1)) ? '0 : tail + 1'b1;
    head_addr  = fifo_addr[head];
    head_data  = fifo_data[head];
  end

  // The ready signals are held low during reset. They are otherwise derived only from registered state.
  assign bus.lng_ready_o = !rst && (cnt < 4'(DEPTH));
  assign bus.lsu_ready_o = !rst && !force_pop;
  assign bus.fifo_cnt_o  = cnt;

  // The storage needs no reset because the per-entry valid bits qualify it.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[tail] <= bus.lng_waddr_i;
      fifo_data[tail] <= bus.lng_wdata_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_vld      <= '0;
      head          <= '0;
      tail          <= '0;
      cnt           <= '0;
      starve        <= '0;
      bus.we_a_o    <= 1'b0;
      bus.waddr_a_o <= '0;
      bus.wdata_a_o <= '0;
      bus.we_b_o    <= 1'b0;
      bus.waddr_b_o <= '0;
      bus.wdata_b_o <= '0;
    end else begin
      bus.we_a_o <= bus.alu_valid_i && (bus.alu_waddr_i != '0);
      if (bus.alu_valid_i) begin
        bus.waddr_a_o <= bus.alu_waddr_i;
        bus.wdata_a_o <= bus.alu_wdata_i;
      end

      if (pop) begin
        bus.we_b_o    <= (head_addr != '0);
        bus.waddr_b_o <= head_addr;
        bus.wdata_b_o <= head_data;
      end else if (lsu_sel) begin
        bus.we_b_o    <= (bus.lsu_waddr_i != '0);
        bus.waddr_b_o <= bus.lsu_waddr_i;
        bus.wdata_b_o <= bus.lsu_wdata_i;
      end else begin
        bus.we_b_o    <= 1'b0;
      end

      // Push and pop can never hit the same slot: push needs non-full and pop needs non-empty.
      if (pop) begin
        fifo_vld[head] <= 1'b0;
        head           <= head_nxt;
      end
      if (push) begin
        fifo_vld[tail] <= 1'b1;
        tail           <= tail_nxt;
      end
      cnt <= cnt + {3'd0, push} - {3'd0, pop};

      if (fifo_empty || pop)
        starve <= '0;
      else if (starve < 4'(STARVE_LIMIT))
        starve <= starve + 4'd1;
    end
  end

  always_comb begin
    pend = '0;
    for (int unsigned i = 0; i < DEPTH; i++)
      if (fifo_vld[i]) pend[fifo_addr[i]] = 1'b1;
    if (bus.we_a_o) pend[bus.waddr_a_o] = 1'b1;
    if (bus.we_b_o) pend[bus.waddr_b_o] = 1'b1;
    pend[0] = 1'b0;
  end

  assign bus.pending_o = pend;

endmodule

// File: tb/tb_riscv_wb_arbiter.sv
// Directed bench for riscv_wb_arbiter with the default parameters (DEPTH=4, STARVE_LIMIT=3).
module tb_riscv_wb_arbiter;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fails;

  riscv_wb_arbiter_if #(.ADDR_WIDTH(6), .DATA_WIDTH(32)) bus ();

  riscv_wb_arbiter #(
    .ADDR_WIDTH(6),
    .DATA_WIDTH(32),
    .DEPTH(4),
    .STARVE_LIMIT(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.alu_valid_i = 1'b0; bus.alu_waddr_i = '0; bus.alu_wdata_i = '0;
    bus.lsu_valid_i = 1'b0; bus.lsu_waddr_i = '0; bus.lsu_wdata_i = '0;
    bus.lng_valid_i = 1'b0; bus.lng_waddr_i = '0; bus.lng_wdata_i = '0;
  endtask

  task automatic alu_single();
    bus.alu_valid_i = 1'b1; bus.alu_waddr_i = 6'd5; bus.alu_wdata_i = 32'h1234;
    tick();
    bus.alu_valid_i = 1'b0;
    check("alu_we_a", 64'(bus.we_a_o), 64'd1);
    check("alu_waddr_a", 64'(bus.waddr_a_o), 64'd5);
    check("alu_wdata_a", 64'(bus.wdata_a_o), 64'h1234);
    check("alu_pending", bus.pending_o, 64'h20);
    tick();
    check("alu_we_a_drop", 64'(bus.we_a_o), 64'd0);
    check("alu_pending_drop", bus.pending_o, 64'h0);
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    idle_inputs();
    rst = 1'b1;
    #3;
    check("rst_we_a", 64'(bus.we_a_o), 64'd0);
    check("rst_we_b", 64'(bus.we_b_o), 64'd0);
    check("rst_waddr_b", 64'(bus.waddr_b_o), 64'd0);
    check("rst_wdata_a", 64'(bus.wdata_a_o), 64'd0);
    check("rst_pending", bus.pending_o, 64'h0);
    check("rst_cnt", 64'(bus.fifo_cnt_o), 64'd0);
    check("rst_lsu_ready", 64'(bus.lsu_ready_o), 64'd0);
    check("rst_lng_ready", 64'(bus.lng_ready_o), 64'd0);
    tick(); tick();
    rst = 1'b0;
    #1;
    check("post_rst_lng_ready", 64'(bus.lng_ready_o), 64'd1);

    // Test 1: a single ALU write.
    alu_single();

    // Test 2: the starvation guard preempts a continuous LSU stream.
    bus.lng_valid_i = 1'b1; bus.lng_waddr_i = 6'd9; bus.lng_wdata_i = 32'h9999;
    bus.lsu_valid_i = 1'b1; bus.lsu_waddr_i = 6'd7; bus.lsu_wdata_i = 32'h7777;
    tick();
    bus.lng_valid_i = 1'b0;
    check("st_cnt1", 64'(bus.fifo_cnt_o), 64'd1);
    check("st_first_lsu", 64'(bus.waddr_b_o), 64'd7);
    for (int k = 0; k < 3; k++) begin
      check("st_lsu_ready", 64'(bus.lsu_ready_o), 64'd1);
      tick();
      check("st_lsu_we_b", 64'(bus.we_b_o), 64'd1);
      check("st_lsu_waddr_b", 64'(bus.waddr_b_o), 64'd7);
    end
    check("st_force_ready", 64'(bus.lsu_ready_o), 64'd0);
    check("st_pending_9_7", bus.pending_o, 64'h280);
    tick();
    check("st_pop_we_b", 64'(bus.we_b_o), 64'd1);
    check("st_pop_waddr_b", 64'(bus.waddr_b_o), 64'd9);
    check("st_pop_wdata_b", 64'(bus.wdata_b_o), 64'h9999);
    check("st_cnt0", 64'(bus.fifo_cnt_o), 64'd0);
    check("st_ready_back", 64'(bus.lsu_ready_o), 64'd1);
    bus.lsu_valid_i = 1'b0;
    tick();
    check("st_idle_we_b", 64'(bus.we_b_o), 64'd0);

    // Test 3a: the FIFO drains in order while there is no LSU traffic.
    for (int i = 1; i <= 4; i++) begin
      bus.lng_valid_i = 1'b1; bus.lng_waddr_i = 6'(i); bus.lng_wdata_i = 32'h100 + 32'(i);
      tick();
      if (i == 1) check("dr_first_idle", 64'(bus.we_b_o), 64'd0);
      else begin
        check("dr_waddr_b", 64'(bus.waddr_b_o), 64'(i - 1));
        check("dr_wdata_b", 64'(bus.wdata_b_o), 64'h100 + 64'(i - 1));
      end
    end
    bus.lng_valid_i = 1'b0;
    tick();
    check("dr_last_waddr_b", 64'(bus.waddr_b_o), 64'd4);
    tick();
    check("dr_done_we_b", 64'(bus.we_b_o), 64'd0);
    check("dr_done_cnt", 64'(bus.fifo_cnt_o), 64'd0);

    // Test 3b: the FIFO fills under LSU saturation and refuses a fifth entry until a pop.
    bus.lsu_valid_i = 1'b1; bus.lsu_waddr_i = 6'd20; bus.lsu_wdata_i = 32'h2020;
    for (int i = 1; i <= 4; i++) begin
      bus.lng_valid_i = 1'b1; bus.lng_waddr_i = 6'(i); bus.lng_wdata_i = 32'h200 + 32'(i);
      tick();
    end
    bus.lng_waddr_i = 6'd5; bus.lng_wdata_i = 32'h205;
    check("full_cnt", 64'(bus.fifo_cnt_o), 64'd4);
    check("full_lng_ready", 64'(bus.lng_ready_o), 64'd0);
    check("full_lsu_ready", 64'(bus.lsu_ready_o), 64'd0);
    check("full_pending", bus.pending_o, 64'h10001E);
    tick();
    check("full_pop_waddr_b", 64'(bus.waddr_b_o), 64'd1);
    check("full_no_push_cnt", 64'(bus.fifo_cnt_o), 64'd3);
    check("full_ready_again", 64'(bus.lng_ready_o), 64'd1);
    tick();
    bus.lng_valid_i = 1'b0;
    bus.lsu_valid_i = 1'b0;
    check("fifth_cnt", 64'(bus.fifo_cnt_o), 64'd4);
    check("fifth_lsu_waddr_b", 64'(bus.waddr_b_o), 64'd20);
    for (int a = 2; a <= 5; a++) begin
      tick();
      check("full_drain_waddr_b", 64'(bus.waddr_b_o), 64'(a));
      check("full_drain_wdata_b", 64'(bus.wdata_b_o), 64'h200 + 64'(a));
    end
    tick();
    check("full_drain_cnt", 64'(bus.fifo_cnt_o), 64'd0);
    check("full_drain_we_b", 64'(bus.we_b_o), 64'd0);

    // Test 4: a long-latency write to x0 is consumed without an enable.
    bus.lng_valid_i = 1'b1; bus.lng_waddr_i = 6'd0; bus.lng_wdata_i = 32'hDEAD;
    check("x0_lng_ready", 64'(bus.lng_ready_o), 64'd1);
    tick();
    bus.lng_valid_i = 1'b0;
    check("x0_cnt1", 64'(bus.fifo_cnt_o), 64'd1);
    check("x0_pending_q", bus.pending_o, 64'h0);
    tick();
    check("x0_cnt0", 64'(bus.fifo_cnt_o), 64'd0);
    check("x0_we_b", 64'(bus.we_b_o), 64'd0);
    check("x0_pending_out", bus.pending_o, 64'h0);

    // Test 5: ALU and LSU write the same address in one cycle.
    bus.alu_valid_i = 1'b1; bus.alu_waddr_i = 6'd12; bus.alu_wdata_i = 32'hAAAA;
    bus.lsu_valid_i = 1'b1; bus.lsu_waddr_i = 6'd12; bus.lsu_wdata_i = 32'hBBBB;
    tick();
    idle_inputs();
    check("same_we_a", 64'(bus.we_a_o), 64'd1);
    check("same_we_b", 64'(bus.we_b_o), 64'd1);
    check("same_waddr_a", 64'(bus.waddr_a_o), 64'd12);
    check("same_waddr_b", 64'(bus.waddr_b_o), 64'd12);
    check("same_wdata_b", 64'(bus.wdata_b_o), 64'hBBBB);
    check("same_pending", bus.pending_o, 64'h1000);
    tick();

    // Test 6: an asynchronous reset with a loaded FIFO and both output stages active.
    bus.lsu_valid_i = 1'b1; bus.lsu_waddr_i = 6'd21; bus.lsu_wdata_i = 32'h2121;
    for (int i = 1; i <= 3; i++) begin
      bus.lng_valid_i = 1'b1; bus.lng_waddr_i = 6'(10 + i); bus.lng_wdata_i = 32'(i);
      if (i == 3) begin
        bus.alu_valid_i = 1'b1; bus.alu_waddr_i = 6'd3; bus.alu_wdata_i = 32'h33;
      end
      tick();
    end
    check("pre_rst_cnt", 64'(bus.fifo_cnt_o), 64'd3);
    check("pre_rst_we_a", 64'(bus.we_a_o), 64'd1);
    check("pre_rst_we_b", 64'(bus.we_b_o), 64'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_we_a", 64'(bus.we_a_o), 64'd0);
    check("mid_rst_we_b", 64'(bus.we_b_o), 64'd0);
    check("mid_rst_pending", bus.pending_o, 64'h0);
    check("mid_rst_cnt", 64'(bus.fifo_cnt_o), 64'd0);
    check("mid_rst_lsu_ready", 64'(bus.lsu_ready_o), 64'd0);
    check("mid_rst_lng_ready", 64'(bus.lng_ready_o), 64'd0);
    idle_inputs();
    tick(); tick();
    rst = 1'b0;
    #1;
    check("post_rst2_cnt", 64'(bus.fifo_cnt_o), 64'd0);
    alu_single();
    tick();
    check("final_we_b", 64'(bus.we_b_o), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, observed running expected done");
    $fatal(1, "timeout");
  end

endmodule
